router_vc_fifo: RTL and testbench
=================================

# router_vc_fifo

Multi-channel input buffer for the router port: NUM_VC independent circular FIFOs share one write port and one read port, with per-channel full, empty, almost-full and occupancy status. Each accepted read returns a credit to the upstream sender one cycle later. It replaces the single-channel port FIFO and adds virtual-channel separation, non-power-of-two depth, full-with-read write acceptance, and sticky error reporting. It sits between the port input decoder (writer) and the crossbar arbiter (reader).

## Interface
- DATA_W, 32, flit width in bits
- DEPTH, 4, entries per VC; any value ≥ 2, not limited to powers of two
- NUM_VC, 2, number of virtual channels; ≥ 1
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH
- VC_W, (NUM_VC>1 ? $clog2(NUM_VC) : 1), derived; width of VC select
- CNT_W, $clog2(DEPTH+1), derived; width of per-VC count
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_vc  in  VC_W  target VC for write
- wr_data  in  DATA_W  flit to store
- rd_en  in  1  read (pop) request
- rd_vc  in  VC_W  VC to read
- rd_data  out  DATA_W  head flit of rd_vc (show-ahead); 0 when rd_vc is empty
- full  out  NUM_VC  per-VC full, count == DEPTH
- empty  out  NUM_VC  per-VC empty, count == 0
- almost_full  out  NUM_VC  per-VC count ≥ AF_THRESH
- count  out  NUM_VC*CNT_W  packed per-VC occupancy; VC v occupies bits [v*CNT_W +: CNT_W]
- credit_valid  out  1  one-cycle pulse: one slot freed
- credit_vc  out  VC_W  VC of the returned credit
- ovf_err  out  NUM_VC  sticky: write rejected because VC full
- udf_err  out  NUM_VC  sticky: read rejected because VC empty
- err_clr  in  1  synchronous clear of ovf_err/udf_err

## Operation
- Per VC: wr_ptr, rd_ptr (range 0..DEPTH-1), count (0..DEPTH). Pointers wrap explicitly from DEPTH-1 to 0, never by natural overflow.
- Read accepted (rd_acc) = rd_en && !empty[rd_vc]. It increments rd_ptr[rd_vc].
- Write accepted (wr_acc) = wr_en && (!full[wr_vc] || (rd_acc && rd_vc == wr_vc)). It stores wr_data at wr_ptr[wr_vc] and increments wr_ptr[wr_vc].
- A write to a full VC is accepted when a read of the same VC is accepted in the same cycle.
- There is no empty-bypass: a read and a write to the same empty VC in the same cycle gives rd rejected and wr accepted. The written flit becomes visible the next cycle, and udf_err is set.
- Count update per VC: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Reads and writes to different VCs update independently.
- wr_vc or rd_vc ≥ NUM_VC: the request is ignored, with no state change and no error flag.
- Errors: ovf_err[v] is set on wr_en to full VC v without a same-VC rd_acc. udf_err[v] is set on rd_en to empty VC v. Both hold until err_clr. If set and err_clr occur in the same cycle, set wins.
- Credit: credit_valid is registered from rd_acc, and credit_vc is registered from rd_vc.
- Storage array is not reset. rd_data is forced to 0 when empty[rd_vc], so no X propagates.

## Timing
- Reset values: all pointers and counts 0; empty = all 1s; full = 0; almost_full = 0; count = 0; credit_valid = 0; credit_vc = 0; ovf_err = udf_err = 0; rd_data = 0.
- Reset asserted mid-operation discards all contents and forces the values above immediately (asynchronously). The first write is accepted on the first rising edge after rst_b deasserts.
- full, empty, almost_full and count are combinational decodes of the registered count. They change the cycle after the accepting edge.
- rd_data is combinational from rd_vc and the registered rd_ptr. Written data becomes readable one cycle after the write (write-to-read latency 1).
- credit_valid pulses exactly one cycle after each rd_acc. Back-to-back reads give a continuous pulse train.
- Sustained throughput: one write plus one read per cycle, including at full.

## Test plan
- Reset, then check status → empty = 2'b11, full = 0, count = 0, rd_data = 0. Drive rst_b low mid-stream with VC0 count 3 → all status returns to reset values immediately.
- Write 0xA0..0xA3 to VC0 (DEPTH 4), then a fifth write 0xA4 → full[0] = 1, almost_full[0] = 1 after the 3rd write, 0xA4 dropped, ovf_err[0] = 1. Read 4 times → 0xA0..0xA3 in order, 4 credit pulses with credit_vc = 0.
- DEPTH = 3: write/read 10 flits 0x10..0x19 interleaved on VC1 → in-order data, pointers wrap 2 → 0 correctly, count never exceeds 3.
- VC0 full, same cycle read VC0 and write 0xBB to VC0 → read returns head, write accepted, count stays 4, no ovf_err, 0xBB emerges 4th.
- VC1 empty, same cycle rd_en and wr_en on VC1 with 0xCC → udf_err[1] = 1, no credit, next cycle rd_data = 0xCC, count[1] = 1. Pulse err_clr → udf_err[1] = 0.
- Write VC0 and read VC1 in the same cycle, each holding 2 flits → count VC0 = 3, count VC1 = 1, and the flit contents of each VC are unaffected by the other VC's access.

Source files
------------

// File: rtl/router_vc_fifo.sv
// router_vc_fifo: NUM_VC independent circular FIFOs sharing one write and one read port,
// with per-VC status, sticky overflow/underflow flags and a registered read credit.
module router_vc_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_VC    = 2,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_W-1:0]       rd_data,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    credit_valid,
    output logic [VC_W-1:0]         credit_vc,
    output logic [NUM_VC-1:0]       ovf_err,
    output logic [NUM_VC-1:0]       udf_err,
    input  logic                    err_clr
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  r_cnt    [NUM_VC];
    logic [NUM_VC-1:0] r_ovf;
    logic [NUM_VC-1:0] r_udf;
    logic              r_credit_valid;
    logic [VC_W-1:0]   r_credit_vc;

    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_af;
    logic [NUM_VC-1:0] w_rd_sel;
    logic [NUM_VC-1:0] w_wr_hit;
    logic [NUM_VC-1:0] w_rd_hit;
    logic [NUM_VC-1:0] w_wr_acc;
    logic [NUM_VC-1:0] w_rd_acc;
    logic [NUM_VC-1:0] w_ovf_set;
    logic [NUM_VC-1:0] w_udf_set;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_af    = '0;
        count   = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            w_full[v]                = (r_cnt[v] == CNT_FULL);
            w_empty[v]               = (r_cnt[v] == '0);
            w_af[v]                  = (r_cnt[v] >= CNT_AF);
            count[v*CNT_W +: CNT_W]  = r_cnt[v];
        end
    end

    // Select lines decode per VC, so an out-of-range wr_vc/rd_vc matches nothing and is ignored.
    always_comb begin
        w_rd_sel  = '0;
        w_wr_hit  = '0;
        w_rd_hit  = '0;
        w_rd_acc  = '0;
        w_wr_acc  = '0;
        w_ovf_set = '0;
        w_udf_set = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            w_rd_sel[v]  = (rd_vc == VC_W'(v));
            w_wr_hit[v]  = wr_en && (wr_vc == VC_W'(v));
            w_rd_hit[v]  = rd_en && w_rd_sel[v];
            w_rd_acc[v]  = w_rd_hit[v] && !w_empty[v];
            w_wr_acc[v]  = w_wr_hit[v] && (!w_full[v] || w_rd_acc[v]);
            w_ovf_set[v] = w_wr_hit[v] && w_full[v] && !w_rd_acc[v];
            w_udf_set[v] = w_rd_hit[v] && w_empty[v];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (w_rd_sel[v] && !w_empty[v]) begin
                rd_data = r_mem[v][r_rd_ptr[v]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_cnt[v]    <= '0;
            end
            r_ovf          <= '0;
            r_udf          <= '0;
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (w_wr_acc[v]) begin
                    r_wr_ptr[v] <= ptr_inc(r_wr_ptr[v]);
                end
                if (w_rd_acc[v]) begin
                    r_rd_ptr[v] <= ptr_inc(r_rd_ptr[v]);
                end
                if (w_wr_acc[v] && !w_rd_acc[v]) begin
                    r_cnt[v] <= r_cnt[v] + CNT_ONE;
                end else if (!w_wr_acc[v] && w_rd_acc[v]) begin
                    r_cnt[v] <= r_cnt[v] - CNT_ONE;
                end
                // A new error event in the same cycle as err_clr keeps the flag set.
                if (w_ovf_set[v]) begin
                    r_ovf[v] <= 1'b1;
                end else if (err_clr) begin
                    r_ovf[v] <= 1'b0;
                end
                if (w_udf_set[v]) begin
                    r_udf[v] <= 1'b1;
                end else if (err_clr) begin
                    r_udf[v] <= 1'b0;
                end
            end
            r_credit_valid <= |w_rd_acc;
            r_credit_vc    <= rd_vc;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (w_wr_acc[v]) begin
                r_mem[v][r_wr_ptr[v]] <= wr_data;
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = w_af;
    assign ovf_err      = r_ovf;
    assign udf_err      = r_udf;
    assign credit_valid = r_credit_valid;
    assign credit_vc    = r_credit_vc;

endmodule

// File: tb/tb_router_vc_fifo.sv
// Bench for router_vc_fifo: a DEPTH 4 and a DEPTH 3 instance share stimulus; per-VC scoreboard
// queues hold written flits and are popped against rd_data on every accepted read.
module tb_router_vc_fifo;

    localparam int D0  = 4;
    localparam int D1  = 3;
    localparam int AF0 = 3;
    localparam int AF1 = 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_vc = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        rd_vc = 1'b0;
    logic        err_clr = 1'b0;

    logic [31:0] rd_a   [2];
    logic [1:0]  full_a [2];
    logic [1:0]  empty_a[2];
    logic [1:0]  af_a   [2];
    logic [1:0]  ovf_a  [2];
    logic [1:0]  udf_a  [2];
    logic        cv_a   [2];
    logic        cvc_a  [2];
    logic [5:0]  cnt0;
    logic [3:0]  cnt1;

    logic [31:0] m_q [2][2][$];
    logic [1:0]  m_ovf [2];
    logic [1:0]  m_udf [2];
    logic        m_cv  [2];
    logic        m_cvc [2];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    router_vc_fifo #(.DATA_W(32), .DEPTH(D0), .NUM_VC(2), .AF_THRESH(AF0)) dut0 (
        .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_a[0]), .full(full_a[0]), .empty(empty_a[0]),
        .almost_full(af_a[0]), .count(cnt0), .credit_valid(cv_a[0]), .credit_vc(cvc_a[0]),
        .ovf_err(ovf_a[0]), .udf_err(udf_a[0]), .err_clr(err_clr)
    );

    router_vc_fifo #(.DATA_W(32), .DEPTH(D1), .NUM_VC(2), .AF_THRESH(AF1)) dut1 (
        .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_a[1]), .full(full_a[1]), .empty(empty_a[1]),
        .almost_full(af_a[1]), .count(cnt1), .credit_valid(cv_a[1]), .credit_vc(cvc_a[1]),
        .ovf_err(ovf_a[1]), .udf_err(udf_a[1]), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int dep(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int afth(input int i);
        return (i == 0) ? AF0 : AF1;
    endfunction

    function automatic logic [31:0] cnt_of(input int i, input int v);
        if (i == 0) return 32'(cnt0[v*3 +: 3]);
        return 32'(cnt1[v*2 +: 2]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 2; v++) m_q[i][v].delete();
            m_ovf[i] = '0;
            m_udf[i] = '0;
            m_cv[i]  = 1'b0;
            m_cvc[i] = 1'b0;
        end
    endtask

    task automatic check_status();
        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 2; v++) begin
                int sz;
                sz = m_q[i][v].size();
                check($sformatf("count[%0d][%0d]", i, v), cnt_of(i, v), 32'(sz));
                check($sformatf("full[%0d][%0d]", i, v), 32'(full_a[i][v]), 32'(sz == dep(i)));
                check($sformatf("empty[%0d][%0d]", i, v), 32'(empty_a[i][v]), 32'(sz == 0));
                check($sformatf("afull[%0d][%0d]", i, v), 32'(af_a[i][v]), 32'(sz >= afth(i)));
                check($sformatf("ovf[%0d][%0d]", i, v), 32'(ovf_a[i][v]), 32'(m_ovf[i][v]));
                check($sformatf("udf[%0d][%0d]", i, v), 32'(udf_a[i][v]), 32'(m_udf[i][v]));
            end
            check($sformatf("credit_valid[%0d]", i), 32'(cv_a[i]), 32'(m_cv[i]));
            check($sformatf("credit_vc[%0d]", i), 32'(cvc_a[i]), 32'(m_cvc[i]));
        end
    endtask

    // One clock of stimulus: check registered state, drive, compare show-ahead data, update model.
    task automatic step(input logic we, input logic wv, input logic [31:0] wd,
                        input logic re, input logic rv, input logic ec);
        @(negedge clk);
        check_status();
        wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv; err_clr = ec;
        #1;
        for (int i = 0; i < 2; i++) begin
            int          szr, szw;
            logic        racc, wacc;
            logic [31:0] exp_d;
            szr   = m_q[i][rv].size();
            szw   = m_q[i][wv].size();
            racc  = re && (szr > 0);
            wacc  = we && ((szw < dep(i)) || (racc && (rv == wv)));
            exp_d = (szr > 0) ? m_q[i][rv][0] : 32'h0;
            check($sformatf("rd_data[%0d]", i), rd_a[i], exp_d);
            if (racc) void'(m_q[i][rv].pop_front());
            if (wacc) m_q[i][wv].push_back(wd);
            for (int v = 0; v < 2; v++) begin
                logic so, su;
                so = we && (wv == v[0]) && (szw == dep(i)) && !(racc && (rv == wv));
                su = re && (rv == v[0]) && (szr == 0);
                if (so) m_ovf[i][v] = 1'b1; else if (ec) m_ovf[i][v] = 1'b0;
                if (su) m_udf[i][v] = 1'b1; else if (ec) m_udf[i][v] = 1'b0;
            end
            m_cv[i]  = racc;
            m_cvc[i] = rv;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_vc = 1'b0; wr_data = '0; rd_en = 1'b0; rd_vc = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        clear_model();
        check_status();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_rd_data[%0d]", tag, i), rd_a[i], 32'h0);
            check($sformatf("%s_empty[%0d]", tag, i), 32'(empty_a[i]), 32'h3);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        clear_model();
        #12 check_reset_state("por");
        @(negedge clk);
        rst_b = 1'b1;

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b0);
            if (k == 2) begin
                check("af_after3", 32'(af_a[0][0]), 32'h1);
                check("notfull_after3", 32'(full_a[0][0]), 32'h0);
            end
        end
        check("full_after5", 32'(full_a[0][0]), 32'h1);
        check("ovf_after5", 32'(ovf_a[0][0]), 32'h1);
        check("cnt_after5", cnt_of(0, 0), 32'h4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 32'h10 + 32'(k), k >= 2, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h30 + 32'(k), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hBB, 1'b1, 1'b0, 1'b0);
        check("fullrw_cnt", cnt_of(0, 0), 32'h4);
        check("fullrw_noovf", 32'(ovf_a[0][0]), 32'h0);
        check("fullrw_credit", 32'(cv_a[0]), 32'h1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b1, 32'hCC, 1'b1, 1'b1, 1'b0);
        check("emptyrw_udf", 32'(udf_a[0][1]), 32'h1);
        check("emptyrw_nocredit", 32'(cv_a[0]), 32'h0);
        check("emptyrw_cnt", cnt_of(0, 1), 32'h1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("errclr_udf", 32'(udf_a[0][1]), 32'h0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        step(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hD1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hE0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hD2, 1'b1, 1'b1, 1'b0);
        check("cross_cnt_vc0", cnt_of(0, 0), 32'h3);
        check("cross_cnt_vc1", cnt_of(0, 1), 32'h1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h70 + 32'(k), 1'b0, 1'b0, 1'b0);
        check("prerst_cnt", cnt_of(0, 0), 32'h3);
        mid_reset();
        step(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
        check("postrst_cnt", cnt_of(0, 0), 32'h1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
